// File: rtl/pulse_train_gen.sv
// rtl/pulse_train_gen.sv - programmable pulse-train source with start/stop handshake.
// Optional continuous mode (burst_len=0) under macro PULSE_TRAIN_CONT_EN.
module pulse_train_gen #(
  parameter int CNT_W   = 16,
  parameter int BURST_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic [CNT_W-1:0]   width,
  input  logic [CNT_W-1:0]   period,
  input  logic [BURST_W-1:0] burst_len,
  output logic               pulse_out,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [BURST_W-1:0] pulse_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_phase, w_phase_nxt;
  logic [CNT_W-1:0]   r_width, w_width_nxt;
  logic [CNT_W-1:0]   r_period, w_period_nxt;
  logic [BURST_W-1:0] r_burst, w_burst_nxt;
  logic [BURST_W-1:0] r_pulse_cnt, w_cnt_nxt;
  logic               r_cont, w_cont_nxt;
  logic               r_pulse, w_pulse_nxt;
  logic               r_busy, w_busy_nxt;
  logic               r_done, w_done_nxt;
  logic               r_err, w_err_nxt;

  logic               w_burst_ok;
  logic               w_cont_req;
  logic               w_cfg_ok;
  logic               w_last;
  logic [CNT_W-1:0]   w_low_len;
  logic [BURST_W-1:0] w_cnt_inc;

`ifdef PULSE_TRAIN_CONT_EN
  assign w_burst_ok = 1'b1;
  assign w_cont_req = (burst_len == '0);
`else
  assign w_burst_ok = (burst_len != '0);
  assign w_cont_req = 1'b0;
`endif

  assign w_cfg_ok  = (width != '0) && (period > width) && w_burst_ok;
  assign w_low_len = r_period - r_width;
  assign w_last    = !r_cont && (r_pulse_cnt == r_burst);
  // Saturating increment; only reachable in continuous mode.
  assign w_cnt_inc = (r_pulse_cnt == '1) ? r_pulse_cnt : r_pulse_cnt + BURST_W'(1);

  always_comb begin
    w_state_nxt  = r_state;
    w_phase_nxt  = r_phase;
    w_width_nxt  = r_width;
    w_period_nxt = r_period;
    w_burst_nxt  = r_burst;
    w_cont_nxt   = r_cont;
    w_cnt_nxt    = r_pulse_cnt;
    w_pulse_nxt  = 1'b0;
    w_busy_nxt   = 1'b0;
    w_done_nxt   = 1'b0;
    w_err_nxt    = 1'b0;
    case (r_state)
      IDLE: begin
        if (start && !stop) begin
          if (w_cfg_ok) begin
            w_state_nxt  = HIGH;
            w_phase_nxt  = CNT_W'(1);
            w_width_nxt  = width;
            w_period_nxt = period;
            w_burst_nxt  = burst_len;
            w_cont_nxt   = w_cont_req;
            w_cnt_nxt    = BURST_W'(1);
            w_pulse_nxt  = 1'b1;
            w_busy_nxt   = 1'b1;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      HIGH: begin
        if (stop) begin
          w_state_nxt = IDLE;
        end else begin
          w_busy_nxt = 1'b1;
          if (r_phase == r_width) begin
            w_state_nxt = LOW;
            w_phase_nxt = CNT_W'(1);
          end else begin
            w_phase_nxt = r_phase + CNT_W'(1);
            w_pulse_nxt = 1'b1;
          end
        end
      end
      LOW: begin
        if (stop) begin
          w_state_nxt = IDLE;
        end else if (r_phase == w_low_len) begin
          if (w_last) begin
            w_state_nxt = IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = HIGH;
            w_phase_nxt = CNT_W'(1);
            w_cnt_nxt   = w_cnt_inc;
            w_pulse_nxt = 1'b1;
            w_busy_nxt  = 1'b1;
          end
        end else begin
          w_phase_nxt = r_phase + CNT_W'(1);
          w_busy_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_phase     <= '0;
      r_width     <= '0;
      r_period    <= '0;
      r_burst     <= '0;
      r_cont      <= 1'b0;
      r_pulse_cnt <= '0;
      r_pulse     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_phase     <= w_phase_nxt;
      r_width     <= w_width_nxt;
      r_period    <= w_period_nxt;
      r_burst     <= w_burst_nxt;
      r_cont      <= w_cont_nxt;
      r_pulse_cnt <= w_cnt_nxt;
      r_pulse     <= w_pulse_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_err       <= w_err_nxt;
    end
  end

  assign pulse_out = r_pulse;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign pulse_cnt = r_pulse_cnt;

endmodule

// File: tb/tb_pulse_train_gen.sv
// tb/tb_pulse_train_gen.sv - scoreboard bench for pulse_train_gen.
// Honours PULSE_TRAIN_CONT_EN for the continuous-mode step.
module tb_pulse_train_gen;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [15:0] width = '0;
  logic [15:0] period = '0;
  logic [7:0]  burst_len = '0;
  logic        pulse_out, busy, done, err;
  logic [7:0]  pulse_cnt;

  logic [11:0] exp_q[$];
  int n_cmp = 0;
  int n_fail = 0;

  pulse_train_gen #(.CNT_W(16), .BURST_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .width(width), .period(period), .burst_len(burst_len),
    .pulse_out(pulse_out), .busy(busy), .done(done), .err(err),
    .pulse_cnt(pulse_cnt)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [11:0] rec(logic p, logic b, logic d, logic e, logic [7:0] c);
    return {p, b, d, e, c};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string tag);
    logic [11:0] obs, expv;
    obs  = {pulse_out, busy, done, err, pulse_cnt};
    expv = exp_q.pop_front();
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s obs=%h exp=%h (pulse,busy,done,err,cnt)", tag, obs, expv);
    end
  endtask

  task automatic drain(string tag);
    while (exp_q.size() > 0) begin
      check(tag);
      if (exp_q.size() > 0) tick();
    end
  endtask

  // Expected cycle stream from t+1 onward, truncated to `limit` cycles.
  task automatic push_burst(int w, int p, int n, int limit);
    int c = 0;
    for (int k = 0; k < n; k++)
      for (int i = 0; i < p; i++) begin
        if (c < limit) exp_q.push_back(rec(i < w, 1'b1, 1'b0, 1'b0, 8'(k + 1)));
        c++;
      end
    if (c < limit) exp_q.push_back(rec(1'b0, 1'b0, 1'b1, 1'b0, 8'(n)));
  endtask

  task automatic start_burst(int w, int p, int n);
    width = 16'(w); period = 16'(p); burst_len = 8'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    #3;
    exp_q.push_back(rec(0, 0, 0, 0, 8'd0));
    check("reset");
    tick(); tick();
    rst_n = 1'b1;
    tick();

    push_burst(2, 5, 3, 16);
    start_burst(2, 5, 3);
    width = 16'd7; period = 16'd9; burst_len = 8'd1;
    drain("burst_2_5_3");
    tick();
    exp_q.push_back(rec(0, 0, 0, 0, 8'd3));
    check("cnt_hold");

    width = 16'd5; period = 16'd5; burst_len = 8'd3; start = 1'b1;
    tick(); start = 1'b0;
    exp_q.push_back(rec(0, 0, 0, 1, 8'd3));
    check("err_w_eq_p");
    tick();
    exp_q.push_back(rec(0, 0, 0, 0, 8'd3));
    check("err_oneshot");
    width = 16'd0; period = 16'd5; start = 1'b1;
    tick(); start = 1'b0;
    exp_q.push_back(rec(0, 0, 0, 1, 8'd3));
    check("err_w_zero");
    width = 16'd2; start = 1'b1; stop = 1'b1;
    tick(); start = 1'b0; stop = 1'b0;
    exp_q.push_back(rec(0, 0, 0, 0, 8'd3));
    check("start_stop_idle");

    push_burst(3, 8, 4, 9);
    start_burst(3, 8, 4);
    drain("stop_pre");
    stop = 1'b1;
    tick(); stop = 1'b0;
    exp_q.push_back(rec(0, 0, 0, 0, 8'd2));
    check("stop_mid_high");
    tick();
    exp_q.push_back(rec(0, 0, 0, 0, 8'd2));
    check("stop_no_done");

    for (int b = 0; b < 3; b++) push_burst(1, 2, 1, 3);
    width = 16'd1; period = 16'd2; burst_len = 8'd1; start = 1'b1;
    tick();
    drain("back_to_back");
    start = 1'b0;
    tick();
    exp_q.push_back(rec(0, 0, 0, 0, 8'd1));
    check("b2b_end");

    push_burst(4, 6, 2, 2);
    start_burst(4, 6, 2);
    drain("pre_reset");
    #2 rst_n = 1'b0;
    #1;
    exp_q.push_back(rec(0, 0, 0, 0, 8'd0));
    check("async_reset");
    tick(); tick();
    rst_n = 1'b1;
    exp_q.push_back(rec(0, 0, 0, 0, 8'd0));
    check("post_reset");
    push_burst(1, 2, 1, 3);
    start_burst(1, 2, 1);
    drain("fresh_burst");

`ifdef PULSE_TRAIN_CONT_EN
    push_burst(1, 3, 10, 30);
    start_burst(1, 3, 0);
    drain("continuous");
    stop = 1'b1;
    tick(); stop = 1'b0;
    exp_q.push_back(rec(0, 0, 0, 0, 8'd10));
    check("cont_stop");
`else
    width = 16'd1; period = 16'd3; burst_len = 8'd0; start = 1'b1;
    tick(); start = 1'b0;
    exp_q.push_back(rec(0, 0, 0, 1, 8'd1));
    check("burst_zero_err");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/pulse_train_gen.md
Name: pulse_train_gen

Overview:
- Clocked digital stimulus source producing a programmable train of rectangular pulses on a single bit.
- Sits directly upstream of the transition primitive: pulse_out drives its xbit input, which converts each edge into a finite-slope real-valued waveform.
- Replaces the free-running fixed-period pulse source with run-time control of width, period and burst length, plus a start/stop handshake, for sequenced neuron-input stimulus.

Parameters:
- CNT_W, 16, width of the width/period cycle counters.
- BURST_W, 8, width of the burst-length field and pulse counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request to begin a burst; sampled on rising clk.
- stop  input  1  abort request; sampled on rising clk.
- width  input  CNT_W  high-phase length in clk cycles.
- period  input  CNT_W  full pulse period in clk cycles.
- burst_len  input  BURST_W  number of pulses in the burst.
- pulse_out  output  1  registered pulse train; feeds transition in.
- busy  output  1  high while a burst is running.
- done  output  1  one-cycle strobe on normal burst completion.
- err  output  1  one-cycle strobe when a start is rejected.
- pulse_cnt  output  BURST_W  number of pulses started in the current or last burst.

Behaviour:
- Reset: clk and reset are decided as stated: one clock; reset is asynchronous and active-low. While rst_n=0, state=IDLE and pulse_out, busy, done, err and pulse_cnt are all 0, immediately (no clk required). Reset mid-burst aborts with no done.
- States: IDLE, HIGH, LOW.
- Start acceptance: start is accepted only in IDLE when stop=0, width!=0, period>width and burst_len!=0.
  - Illegal config: err=1 for 1 cycle; state stays IDLE.
  - Start while busy: ignored, no err.
  - start and stop together in IDLE: stop wins; start ignored, no err.
- Config capture: width, period and burst_len are latched on accept; later input changes have no effect until the next accept.
- Timing, with start accepted at edge t:
  - Cycles t+1 .. t+width: pulse_out=1 (HIGH).
  - Cycles t+width+1 .. t+period: pulse_out=0 (LOW).
  - Pulse k (k=0..N-1) starts at t+k*period+1.
  - busy=1 from t+1 until the burst ends.
- pulse_cnt: cleared to 0 on accept; increments by 1 in the same cycle pulse_out rises, so it is 1 during the first HIGH. Held after done or stop until the next accept.
- Completion: when the LOW phase of pulse N ends, state returns to IDLE at cycle t+N*period+1. In that cycle busy=0 and done=1 for 1 cycle.
  - A start in that same cycle is accepted, giving back-to-back bursts with no gap cycle.
- Stop while busy: at the next cycle pulse_out=0, busy=0 and state=IDLE, even mid-HIGH (truncated pulse allowed). done is not asserted.
- Counters: internal phase counter is CNT_W bits, counts 1..width then 1..(period-width); no wrap is possible because period is at most 2^CNT_W-1. Burst counter is BURST_W bits, no wrap.
- Glitch freedom: all outputs are registered; there are no combinational paths from inputs to outputs.

Optional Feature:
- Macro: PULSE_TRAIN_CONT_EN.
- Defined: burst_len=0 is legal and means continuous mode. The train repeats until stop or reset; done is never asserted; pulse_cnt saturates at 2^BURST_W-1.
- Undefined: burst_len=0 is illegal; start is rejected with err=1 as above.

Test Plan:
- width=2, period=5, burst_len=3, start at t -> pulse_out=1 at t+1..2, t+6..7 and t+11..12, 0 otherwise; done=1 and busy=0 at t+16; pulse_cnt=3.
- width=5, period=5 (also width=0) -> err=1 for 1 cycle, busy stays 0, pulse_out stays 0.
- width=3, period=8, burst_len=4; stop during the second HIGH -> pulse_out=0 and busy=0 the next cycle, no done, pulse_cnt=2.
- burst_len=1, width=1, period=2; start held high continuously -> the start at the done cycle is accepted, pulse_out=1 again on the next cycle, no idle gap.
- rst_n driven low mid-HIGH between clk edges -> pulse_out and busy fall to 0 immediately; after release, the next start behaves as fresh with pulse_cnt=0.
- With PULSE_TRAIN_CONT_EN, burst_len=0, width=1, period=3 -> 10 periods with no done, then stop ends the train; without the macro, the same stimulus gives err=1.
